// File: rtl/vending_pkg.sv
// -----------------------------------------------------------------------------
// vending_pkg
// Shared definitions for the vending payment path: amount width, coin
// values and the payment-stage state encoding.
// -----------------------------------------------------------------------------
package vending_pkg;

    // Width of due / paid / refund amounts (maximum 31 units).
    localparam int PAY_W = 5;

    // Coin values in units.
    localparam logic [PAY_W-1:0] COIN1_V  = 5'd1;
    localparam logic [PAY_W-1:0] COIN5_V  = 5'd5;
    localparam logic [PAY_W-1:0] COIN10_V = 5'd10;

    // Payment-stage states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_PAID    = 2'd2,
        ST_REFUND  = 2'd3
    } pay_state_e;

endpackage : vending_pkg

// File: rtl/pay_collector_idle_timer.sv
// -----------------------------------------------------------------------------
// idle_timer
// Clearable up-counter that flags expiry once CYCLES-1 consecutive
// uncleared cycles have elapsed. Only built when PAY_TIMEOUT_EN is defined.
//
// Ports:
//   clk_i     system clock
//   rst_n_i   synchronous active-low reset
//   clear_i   forces the count back to zero
//   expire_o  high while the count sits at CYCLES-1
// -----------------------------------------------------------------------------
`ifdef PAY_TIMEOUT_EN
module idle_timer #(
    parameter int CYCLES = 50000000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clear_i,
    output logic expire_o
);

    localparam int               CNT_W = (CYCLES > 2) ? $clog2(CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    // Idle counter: clears on request, saturates at the terminal value.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (cnt_q != LAST) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign expire_o = (cnt_q == LAST);

endmodule : idle_timer
`endif

// File: rtl/pay_collector.sv
// -----------------------------------------------------------------------------
// pay_collector
// Payment stage in front of the change computation stage. Latches the amount
// due on start, accumulates coin pulses, flags paid-OK, and handles cancel /
// refund and coin rejection. All outputs are registered.
//
// Optional feature: define PAY_TIMEOUT_EN to auto-refund after TIMEOUT_CYCLES
// idle cycles in COLLECT (idle_timer sub-module).
//
// Ports:
//   clk            system clock (posedge)
//   rst_n          synchronous active-low reset
//   start          pulse: latch due and open collection (ignored if due==0)
//   due            amount due, sampled on accepted start
//   coin_1/5/10    coin pulses of 1, 5 and 10 units
//   cancel         pulse: abort and refund
//   change_taken   pulse from downstream: transaction finished
//   real_pay       accumulated paid amount
//   pay_ok         high while in PAID
//   refund_pulse   one-cycle refund strobe
//   refund_amount  refund value, zero when refund_pulse is low
//   coin_reject    one-cycle pulse, the coin(s) this cycle were refused
//   busy           high in COLLECT, PAID and REFUND
// -----------------------------------------------------------------------------
module pay_collector
    import vending_pkg::*;
#(
    parameter int PAY_W          = vending_pkg::PAY_W,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [PAY_W-1:0] due,
    input  logic             coin_1,
    input  logic             coin_5,
    input  logic             coin_10,
    input  logic             cancel,
    input  logic             change_taken,
    output logic [PAY_W-1:0] real_pay,
    output logic             pay_ok,
    output logic             refund_pulse,
    output logic [PAY_W-1:0] refund_amount,
    output logic             coin_reject,
    output logic             busy
);

    // A timeout of fewer than two cycles cannot be represented by the timer.
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("pay_collector: TIMEOUT_CYCLES must be at least 2");
    end

    pay_state_e       state_q;
    logic [PAY_W-1:0] due_q;
    logic [PAY_W-1:0] real_pay_q;
    logic [PAY_W-1:0] refund_amount_q;
    logic             pay_ok_q;
    logic             refund_pulse_q;
    logic             coin_reject_q;
    logic             busy_q;

    logic             coin_any_s;
    logic             coin_multi_s;
    logic [PAY_W-1:0] coin_v_s;
    logic [PAY_W:0]   sum_s;
    logic             ovf_s;
    logic             timeout_s;
    logic             abort_s;
    logic             accept_s;

    // Coin priority (10 > 5 > 1) and overflow-checked sum, one extra bit wide.
    always_comb begin
        coin_any_s   = coin_1 | coin_5 | coin_10;
        coin_multi_s = 1'b0;
        coin_v_s     = '0;
        if (coin_10) begin
            coin_v_s     = PAY_W'(COIN10_V);
            coin_multi_s = coin_5 | coin_1;
        end else if (coin_5) begin
            coin_v_s     = PAY_W'(COIN5_V);
            coin_multi_s = coin_1;
        end else if (coin_1) begin
            coin_v_s     = PAY_W'(COIN1_V);
        end else begin
            coin_v_s     = '0;
        end
        sum_s    = {1'b0, real_pay_q} + {1'b0, coin_v_s};
        ovf_s    = sum_s[PAY_W];
        abort_s  = cancel | timeout_s;
        accept_s = (state_q == ST_COLLECT) && !abort_s && coin_any_s && !ovf_s;
    end

`ifdef PAY_TIMEOUT_EN
    // Held clear outside COLLECT so it starts from zero on entry.
    idle_timer #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .clear_i  ((state_q != ST_COLLECT) || accept_s),
        .expire_o (timeout_s)
    );
`else
    assign timeout_s = 1'b0;
`endif

    // Payment FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            due_q           <= '0;
            real_pay_q      <= '0;
            refund_amount_q <= '0;
            pay_ok_q        <= 1'b0;
            refund_pulse_q  <= 1'b0;
            coin_reject_q   <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            refund_pulse_q  <= 1'b0;
            refund_amount_q <= '0;
            coin_reject_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    real_pay_q    <= '0;
                    pay_ok_q      <= 1'b0;
                    coin_reject_q <= coin_any_s;
                    if (start && (due != '0)) begin
                        due_q   <= due;
                        state_q <= ST_COLLECT;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                ST_COLLECT: begin
                    if (abort_s) begin
                        // Abort beats any coin or completion in the same cycle.
                        coin_reject_q   <= coin_any_s;
                        refund_pulse_q  <= 1'b1;
                        refund_amount_q <= real_pay_q;
                        state_q         <= ST_REFUND;
                    end else begin
                        coin_reject_q <= coin_multi_s | (coin_any_s & ovf_s);
                        if (accept_s) begin
                            real_pay_q <= sum_s[PAY_W-1:0];
                            if (sum_s >= {1'b0, due_q}) begin
                                state_q  <= ST_PAID;
                                pay_ok_q <= 1'b1;
                            end else begin
                                state_q  <= ST_COLLECT;
                            end
                        end else begin
                            real_pay_q <= real_pay_q;
                        end
                    end
                end
                ST_PAID: begin
                    coin_reject_q <= coin_any_s;
                    if (change_taken) begin
                        state_q    <= ST_IDLE;
                        real_pay_q <= '0;
                        pay_ok_q   <= 1'b0;
                        busy_q     <= 1'b0;
                    end else begin
                        state_q    <= ST_PAID;
                    end
                end
                ST_REFUND: begin
                    coin_reject_q <= coin_any_s;
                    state_q       <= ST_IDLE;
                    real_pay_q    <= '0;
                    busy_q        <= 1'b0;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    real_pay_q <= '0;
                    pay_ok_q   <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign real_pay      = real_pay_q;
    assign pay_ok        = pay_ok_q;
    assign refund_pulse  = refund_pulse_q;
    assign refund_amount = refund_amount_q;
    assign coin_reject   = coin_reject_q;
    assign busy          = busy_q;

endmodule : pay_collector

// File: tb/tb_pay_collector.sv
// -----------------------------------------------------------------------------
// tb_pay_collector
// Directed scenarios with literal expectations followed by randomized
// traffic, all checked every cycle against a transaction-level model.
// -----------------------------------------------------------------------------
module tb_pay_collector;

    localparam int T = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [4:0] due = 5'd0;
    logic       coin_1 = 1'b0;
    logic       coin_5 = 1'b0;
    logic       coin_10 = 1'b0;
    logic       cancel = 1'b0;
    logic       change_taken = 1'b0;
    logic [4:0] real_pay;
    logic       pay_ok;
    logic       refund_pulse;
    logic [4:0] refund_amount;
    logic       coin_reject;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // Model: phase 0 idle, 1 collecting, 2 paid, 3 refunding
    int m_ph = 0, m_paid = 0, m_due = 0, m_idle = 0;
    int e_rej = 0, e_rp = 0, e_ra = 0;

    pay_collector #(.PAY_W(5), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .due(due),
        .coin_1(coin_1), .coin_5(coin_5), .coin_10(coin_10),
        .cancel(cancel), .change_taken(change_taken),
        .real_pay(real_pay), .pay_ok(pay_ok), .refund_pulse(refund_pulse),
        .refund_amount(refund_amount), .coin_reject(coin_reject), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge from the sampled inputs.
    task automatic model_edge();
        int ncoin, v;
        bit tmo;
        e_rej = 0; e_rp = 0; e_ra = 0;
        ncoin = int'(coin_1) + int'(coin_5) + int'(coin_10);
        if (!rst_n) begin
            m_ph = 0; m_paid = 0; m_due = 0; m_idle = 0;
        end else begin
            case (m_ph)
                0: begin
                    e_rej = (ncoin > 0);
                    if (start && due != 0) begin
                        m_ph = 1; m_due = due; m_idle = 0; m_paid = 0;
                    end
                end
                1: begin
`ifdef PAY_TIMEOUT_EN
                    tmo = (m_idle == T - 1);
`else
                    tmo = 1'b0;
`endif
                    if (cancel || tmo) begin
                        e_rej = (ncoin > 0); e_rp = 1; e_ra = m_paid; m_ph = 3;
                    end else if (ncoin > 0) begin
                        v = coin_10 ? 10 : (coin_5 ? 5 : 1);
                        e_rej = (ncoin > 1);
                        if (m_paid + v > 31) begin
                            e_rej = 1; m_idle++;
                        end else begin
                            m_paid += v; m_idle = 0;
                            if (m_paid >= m_due) m_ph = 2;
                        end
                    end else begin
                        m_idle++;
                    end
                end
                2: begin
                    e_rej = (ncoin > 0);
                    if (change_taken) begin m_ph = 0; m_paid = 0; end
                end
                default: begin
                    e_rej = (ncoin > 0); m_ph = 0; m_paid = 0;
                end
            endcase
        end
    endtask

    // One clock: update model at the edge, compare #1 later, drop pulses.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("real_pay", real_pay, m_paid);
        chk("pay_ok", pay_ok, (m_ph == 2) ? 1 : 0);
        chk("busy", busy, (m_ph != 0) ? 1 : 0);
        chk("refund_pulse", refund_pulse, e_rp);
        chk("refund_amount", refund_amount, e_ra);
        chk("coin_reject", coin_reject, e_rej);
        start = 0; coin_1 = 0; coin_5 = 0; coin_10 = 0;
        cancel = 0; change_taken = 0;
    endtask

    task automatic begin_txn(input int d);
        start = 1; due = 5'(d); step();
    endtask

    initial begin
        // Reset
        rst_n = 0; step(); step();
        chk("rst_real_pay", real_pay, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1;

        // Exact pay
        begin_txn(7);
        chk("exact_busy", busy, 1);
        coin_5 = 1; step(); chk("exact_5", real_pay, 5);
        coin_1 = 1; step(); chk("exact_6", real_pay, 6);
        chk("exact_notok", pay_ok, 0);
        coin_1 = 1; step(); chk("exact_7", real_pay, 7);
        chk("exact_ok", pay_ok, 1);
        change_taken = 1; step();
        chk("exact_done_pay", real_pay, 0);
        chk("exact_done_ok", pay_ok, 0);
        chk("exact_done_busy", busy, 0);

        // Overpay
        begin_txn(3);
        coin_10 = 1; step(); chk("over_10", real_pay, 10);
        chk("over_ok", pay_ok, 1);
        coin_1 = 1; step(); chk("over_rej", coin_reject, 1);
        chk("over_hold", real_pay, 10);
        change_taken = 1; step();

        // Cancel
        begin_txn(15);
        coin_5 = 1; step(); coin_1 = 1; step();
        cancel = 1; step();
        chk("cancel_rp", refund_pulse, 1);
        chk("cancel_ra", refund_amount, 6);
        step();
        chk("cancel_rp_end", refund_pulse, 0);
        chk("cancel_pay0", real_pay, 0);

        // Overflow and simultaneous coins
        begin_txn(31);
        coin_10 = 1; step(); coin_10 = 1; step(); coin_5 = 1; step();
        chk("ovf_25", real_pay, 25);
        coin_10 = 1; step();
        chk("ovf_rej", coin_reject, 1);
        chk("ovf_hold", real_pay, 25);
        coin_5 = 1; coin_1 = 1; step();
        chk("sim_30", real_pay, 30);
        chk("sim_rej", coin_reject, 1);
        step();
        chk("sim_rej_once", coin_reject, 0);
        cancel = 1; step(); step();

        // Boundary
        begin_txn(0);
        chk("due0_busy", busy, 0);
        coin_1 = 1; step(); chk("idle_rej", coin_reject, 1);
        begin_txn(9);
        coin_5 = 1; step(); coin_1 = 1; step();
        chk("pre_rst_6", real_pay, 6);
        rst_n = 0; step();
        chk("midrst_pay", real_pay, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_rp", refund_pulse, 0);
        rst_n = 1;

`ifdef PAY_TIMEOUT_EN
        // Timeout after T idle cycles
        begin_txn(9);
        coin_5 = 1; step();
        for (int i = 0; i < T - 1; i++) step();
        chk("tmo_early", refund_pulse, 0);
        step();
        chk("tmo_rp", refund_pulse, 1);
        chk("tmo_ra", refund_amount, 5);
        step();
        // Coin at cycle 6 restarts the count
        begin_txn(9);
        coin_5 = 1; step();
        for (int i = 0; i < 5; i++) step();
        coin_1 = 1; step();
        for (int i = 0; i < 2; i++) step();
        chk("tmo_restart", refund_pulse, 0);
        for (int i = 0; i < T - 3; i++) step();
        chk("tmo_restart_early", refund_pulse, 0);
        step();
        chk("tmo_restart_rp", refund_pulse, 1);
        chk("tmo_restart_ra", refund_amount, 6);
        step();
`endif

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            rst_n        = ($urandom_range(0, 199) != 0);
            start        = ($urandom_range(0, 7) == 0);
            due          = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            coin_1       = ($urandom_range(0, 3) == 0);
            coin_5       = ($urandom_range(0, 4) == 0);
            coin_10      = ($urandom_range(0, 5) == 0);
            cancel       = ($urandom_range(0, 29) == 0);
            change_taken = ($urandom_range(0, 5) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_pay_collector

// File: doc/pay_collector.md
Name: pay_collector

Overview:
- Payment-stage block directly upstream of the change computation stage.
- Accepts single-cycle coin pulses and accumulates the amount paid against a latched amount due.
- Presents a stable 5-bit paid amount, which downstream reads as get_real_pay, together with a paid-OK level.
- Handles cancel/refund, coin rejection on overflow or wrong state, and an optional inactivity timeout.

Parameters:
- PAY_W, 5, width of the due, paid and refund amounts (maximum 31 units).
- TIMEOUT_CYCLES, 50000000, idle cycles in COLLECT before auto-refund (used only with the macro).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; latches due and opens collection.
- due  in  PAY_W  amount due; sampled only on an accepted start.
- coin_1  in  1  one-cycle pulse, 1 unit inserted.
- coin_5  in  1  one-cycle pulse, 5 units inserted.
- coin_10  in  1  one-cycle pulse, 10 units inserted.
- cancel  in  1  one-cycle pulse; user aborts payment.
- change_taken  in  1  one-cycle pulse from downstream; transaction finished.
- real_pay  out  PAY_W  accumulated paid amount.
- pay_ok  out  1  high while in PAID.
- refund_pulse  out  1  one-cycle pulse; refund_amount is valid in the same cycle.
- refund_amount  out  PAY_W  amount to return; 0 when refund_pulse is low.
- coin_reject  out  1  one-cycle pulse; the coin this cycle was refused.
- busy  out  1  high in COLLECT, PAID and REFUND.

Behaviour:
- Reset: while rst_n=0 at posedge, state=IDLE and every output is 0; due_q=0. Reset mid-transaction discards collected money with no refund pulse.
- Registered outputs; no combinational input-to-output path. An event sampled at edge N is visible after edge N.
- States are IDLE, COLLECT, PAID, REFUND.
- IDLE:
  - real_pay=0.
  - start with due!=0 → COLLECT; due_q<=due.
  - start with due=0 is ignored.
  - Coins are rejected.
- COLLECT, single coin:
  - Coin value v: sum=real_pay+v computed at PAY_W+1 bits.
  - sum>31 → coin_reject, real_pay unchanged.
  - Otherwise real_pay<=sum.
  - If sum>=due_q, go to PAID on the same edge.
- COLLECT, simultaneous coins: priority coin_10 > coin_5 > coin_1. Only the highest is evaluated; every other asserted coin raises coin_reject (one pulse total).
- COLLECT, cancel:
  - → REFUND with refund_amount<=real_pay.
  - Any coin in the same cycle is rejected; cancel wins over completion.
- COLLECT, start: ignored; due_q is not reloaded.
- REFUND: lasts exactly 1 cycle with refund_pulse=1. Next edge → IDLE, real_pay<=0, refund_amount<=0.
- PAID:
  - real_pay and pay_ok held stable; downstream computes change here.
  - Coins are rejected; cancel and start are ignored.
  - change_taken → IDLE, real_pay<=0, pay_ok<=0.
- change_taken outside PAID is ignored.
- Overpayment is legal, e.g. due 7 paid with 10 gives real_pay=10.

Optional Feature:
- Macro: PAY_TIMEOUT_EN.
- With the macro:
  - An idle counter runs in COLLECT.
  - It clears on entry to COLLECT and on each accepted coin.
  - When it reaches TIMEOUT_CYCLES-1, the next edge acts exactly as cancel (→ REFUND with the current real_pay, possibly 0).
  - A rejected coin does not clear the counter.
- Without the macro: no counter logic; COLLECT waits indefinitely; TIMEOUT_CYCLES is unused.

Decomposition:
- Shared package vending_pkg holds:
  - PAY_W;
  - coin value constants COIN1_V=1, COIN5_V=5, COIN10_V=10;
  - state enum/encoding for IDLE, COLLECT, PAID, REFUND.
- One sub-module, idle_timer: a clearable counter with expiry pulse, instantiated only under PAY_TIMEOUT_EN.
- Coin priority and add/saturation logic stay inline.

Test Plan:
- Exact pay: reset; start due=7; coin_5, coin_1, coin_1 → real_pay 5, 6, 7; pay_ok=1 after the third coin; change_taken → real_pay=0, pay_ok=0, busy=0.
- Overpay: start due=3; coin_10 → real_pay=10, pay_ok=1; a further coin_1 in PAID → coin_reject, real_pay stays 10.
- Cancel: start due=15; coin_5, coin_1; cancel → one cycle refund_pulse=1 with refund_amount=6, then IDLE with real_pay=0.
- Overflow/simultaneous: start due=31; 2×coin_10, then coin_5 → 25; coin_10 → reject, still 25; coin_5+coin_1 together → real_pay=30 and one coin_reject pulse.
- Boundary: start due=0 → ignored, busy=0; coin in IDLE → coin_reject; rst_n=0 mid-COLLECT with real_pay=6 → all outputs 0 and no refund_pulse.
- PAY_TIMEOUT_EN with TIMEOUT_CYCLES=8: start due=9; coin_5; 8 idle cycles → refund_pulse with refund_amount=5. Repeat with a coin at cycle 6 → counter restarts and no refund occurs at cycle 8.
